// File: rtl/load_port_arbiter_if.sv
// ============================================================================
// Module   : load_port_arbiter_if
// Brief    : Requester, shared-port and status signals of the load-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_port_arbiter_if;
    // Requester 0: SPI-slave loader
    logic        req_0_i;
    logic [31:0] addr_0_i;
    logic        we_0_i;
    logic [3:0]  be_0_i;
    logic [31:0] wdata_0_i;
    logic        last_0_i;
    logic        gnt_0_o;
    logic        rvalid_0_o;
    logic [31:0] rdata_0_o;
    // Requester 1: JTAG debug
    logic        req_1_i;
    logic [31:0] addr_1_i;
    logic        we_1_i;
    logic [3:0]  be_1_i;
    logic [31:0] wdata_1_i;
    logic        last_1_i;
    logic        gnt_1_o;
    logic        rvalid_1_o;
    logic [31:0] rdata_1_o;
    // Shared memory port
    logic        req_o;
    logic [31:0] addr_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    // Status
    logic        err_o;
    logic        owner_o;

    modport slave (
        input  req_0_i, addr_0_i, we_0_i, be_0_i, wdata_0_i, last_0_i,
        output gnt_0_o, rvalid_0_o, rdata_0_o,
        input  req_1_i, addr_1_i, we_1_i, be_1_i, wdata_1_i, last_1_i,
        output gnt_1_o, rvalid_1_o, rdata_1_o,
        output req_o, addr_o, we_o, be_o, wdata_o,
        input  gnt_i, rvalid_i, rdata_i,
        output err_o, owner_o
    );

    modport master (
        output req_0_i, addr_0_i, we_0_i, be_0_i, wdata_0_i, last_0_i,
        input  gnt_0_o, rvalid_0_o, rdata_0_o,
        output req_1_i, addr_1_i, we_1_i, be_1_i, wdata_1_i, last_1_i,
        input  gnt_1_o, rvalid_1_o, rdata_1_o,
        input  req_o, addr_o, we_o, be_o, wdata_o,
        output gnt_i, rvalid_i, rdata_i,
        input  err_o, owner_o
    );
endinterface : load_port_arbiter_if

`default_nettype wire

// File: rtl/load_port_arbiter.sv
// ============================================================================
// Module   : load_port_arbiter
// Brief    : Two-requester burst-locking arbiter for one memory port, with an
//            owner FIFO that routes in-order responses back to the requester.
//            Define LOAD_ARB_FIXED_PRIO_EN to make requester 1 win every tie.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_port_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    load_port_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic               fifo_q [OUTSTANDING];
`ifndef LOAD_ARB_FIXED_PRIO_EN
    logic               last_owner_q, last_owner_d;
`endif

    logic w_pop, w_orphan, w_blocked, w_any, w_pick_id;
    logic w_own_valid, w_cur, w_cur_req, w_cur_last;
    logic w_req, w_beat, w_pop_id, w_rvalid0, w_rvalid1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_pop     = bus.rvalid_i && (count_q != '0);
        w_orphan  = bus.rvalid_i && (count_q == '0);
        // A response popping in this cycle frees the slot for a beat granted now.
        w_blocked = (count_q == c_depth) && !w_pop;
        w_any     = bus.req_0_i || bus.req_1_i;
`ifdef LOAD_ARB_FIXED_PRIO_EN
        w_pick_id = bus.req_1_i;
`else
        w_pick_id = (bus.req_0_i && bus.req_1_i) ? ~last_owner_q : bus.req_1_i;
`endif

        w_own_valid = 1'b0;
        w_cur       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_own_valid = w_any && !w_blocked;
                w_cur       = w_pick_id;
            end
            ST_OWN0: begin
                w_own_valid = 1'b1;
                w_cur       = 1'b0;
            end
            ST_OWN1: begin
                w_own_valid = 1'b1;
                w_cur       = 1'b1;
            end
            default: begin
                w_own_valid = 1'b0;
                w_cur       = 1'b0;
            end
        endcase

        w_cur_req  = w_cur ? bus.req_1_i  : bus.req_0_i;
        w_cur_last = w_cur ? bus.last_1_i : bus.last_0_i;
        w_req      = rst_n && w_own_valid && w_cur_req && !w_blocked;
        w_beat     = w_req && bus.gnt_i;

        state_d = state_q;
        owner_d = owner_q;
        if ((state_q == ST_IDLE) && w_own_valid) begin
            state_d = w_cur ? ST_OWN1 : ST_OWN0;
            owner_d = w_cur;
        end
        if (w_beat && w_cur_last) begin
            state_d = ST_IDLE;
        end
`ifndef LOAD_ARB_FIXED_PRIO_EN
        last_owner_d = last_owner_q;
        if (w_beat && w_cur_last) begin
            last_owner_d = w_cur;
        end
`endif

        case ({w_beat, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        w_pop_id  = fifo_q[rptr_q];
        w_rvalid0 = w_pop && !w_pop_id;
        w_rvalid1 = w_pop &&  w_pop_id;
        err_d     = err_q || w_orphan;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                fifo_q[i] <= 1'b0;
            end
`ifndef LOAD_ARB_FIXED_PRIO_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            count_q <= count_d;
            if (w_beat) begin
                fifo_q[wptr_q] <= w_cur;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (w_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
`ifndef LOAD_ARB_FIXED_PRIO_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign bus.req_o   = w_req;
    assign bus.addr_o  = !w_req ? '0 : (w_cur ? bus.addr_1_i  : bus.addr_0_i);
    assign bus.we_o    = w_req && (w_cur ? bus.we_1_i : bus.we_0_i);
    assign bus.be_o    = !w_req ? '0 : (w_cur ? bus.be_1_i    : bus.be_0_i);
    assign bus.wdata_o = !w_req ? '0 : (w_cur ? bus.wdata_1_i : bus.wdata_0_i);

    assign bus.gnt_0_o    = w_beat && !w_cur;
    assign bus.gnt_1_o    = w_beat &&  w_cur;
    assign bus.rvalid_0_o = w_rvalid0;
    assign bus.rvalid_1_o = w_rvalid1;
    assign bus.rdata_0_o  = w_rvalid0 ? bus.rdata_i : '0;
    assign bus.rdata_1_o  = w_rvalid1 ? bus.rdata_i : '0;

    assign bus.err_o   = err_q;
    assign bus.owner_o = owner_q;

endmodule : load_port_arbiter

`default_nettype wire
